// File: rtl/interrupt_servicer_pkg.sv
// -----------------------------------------------------------------------------
// PKG_pwm: shared definitions for the PWM / interrupt slice.
//   PWM_WIDTH       - number of interrupt sources (one per PWM channel)
//   IRQ_ID_W        - width of an index into the source vector
//   irq_srv_state_t - interrupt servicer FSM states
// -----------------------------------------------------------------------------
package PKG_pwm;

    localparam int unsigned PWM_WIDTH = 8;
    localparam int unsigned IRQ_ID_W  = $clog2(PWM_WIDTH);

    typedef enum logic [2:0] {
        IDLE,
        PRESENT,
        ACK,
        SPUR,
        HOLDOFF
    } irq_srv_state_t;

endpackage

// File: rtl/interrupt_servicer_if.sv
// -----------------------------------------------------------------------------
// interrupt_servicer_if: bundle between the interrupt matrix / CPU side and
// the interrupt servicer.
//   interrupt_in  - raw interrupt sources (same vector as the matrix input)
//   interrupt_req - level request from the interrupt matrix
//   cpu_ack       - one-cycle "vector consumed" pulse from the CPU
//   irq_vld       - a serviced vector is being presented
//   irq_id        - index of the presented source
//   irq_pending   - sticky pending bits
//   int_ack       - one-cycle acknowledge pulse to the interrupt matrix
//   spurious_cnt  - saturating count of requests with nothing pending
// master = matrix/CPU side, slave = servicer.
// -----------------------------------------------------------------------------
interface interrupt_servicer_if;
    import PKG_pwm::*;

    logic [PWM_WIDTH-1:0] interrupt_in;
    logic                 interrupt_req;
    logic                 cpu_ack;
    logic                 irq_vld;
    logic [IRQ_ID_W-1:0]  irq_id;
    logic [PWM_WIDTH-1:0] irq_pending;
    logic                 int_ack;
    logic [7:0]           spurious_cnt;

    modport master (
        output interrupt_in, interrupt_req, cpu_ack,
        input  irq_vld, irq_id, irq_pending, int_ack, spurious_cnt
    );

    modport slave (
        input  interrupt_in, interrupt_req, cpu_ack,
        output irq_vld, irq_id, irq_pending, int_ack, spurious_cnt
    );

endinterface

// File: rtl/interrupt_servicer_prio_enc.sv
// -----------------------------------------------------------------------------
// irq_prio_enc: combinational priority encoder, index 0 is highest priority.
//   req_vec - request bits (any number may be set)
//   idx     - index of the lowest set bit (0 when none set)
//   found   - at least one bit of req_vec is set
// -----------------------------------------------------------------------------
module irq_prio_enc
    import PKG_pwm::*;
(
    input  logic [PWM_WIDTH-1:0] req_vec,
    output logic [IRQ_ID_W-1:0]  idx,
    output logic                 found
);

    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < PWM_WIDTH; i++) begin
            if (!found && req_vec[i]) begin
                found = 1'b1;
                idx   = IRQ_ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/interrupt_servicer.sv
// -----------------------------------------------------------------------------
// interrupt_servicer: captures rising edges of the interrupt sources into
// sticky pending bits, presents the highest-priority pending source to the
// CPU, acknowledges the interrupt matrix once the CPU consumes the vector,
// then holds off for HOLDOFF_CYCLES before accepting another request.
// Requests with nothing pending are acknowledged and counted as spurious.
//   clk   - rising-edge clock
//   reset - asynchronous, active-high reset
//   bus   - interrupt_servicer_if slave modport (see interface header)
// Parameter HOLDOFF_CYCLES: idle cycles after each int_ack, legal 1..255.
// -----------------------------------------------------------------------------
module interrupt_servicer
    import PKG_pwm::*;
#(
    parameter int unsigned HOLDOFF_CYCLES = 4
)
(
    input  logic                 clk,
    input  logic                 reset,
    interrupt_servicer_if.slave  bus
);

    irq_srv_state_t       state, state_next;

    logic [PWM_WIDTH-1:0] in_q;
    logic                 edge_armed;
    logic [PWM_WIDTH-1:0] pending;
    logic [IRQ_ID_W-1:0]  id_q;
    logic [7:0]           hold_cnt;
    logic [7:0]           spur_cnt;

    logic [PWM_WIDTH-1:0] rise;
    logic [PWM_WIDTH-1:0] clr_mask;
    logic [IRQ_ID_W-1:0]  prio_idx;
    logic                 prio_found;
    logic                 load_id;
    logic                 irq_vld_c;
    logic                 int_ack_c;

    irq_prio_enc u_prio (
        .req_vec (pending),
        .idx     (prio_idx),
        .found   (prio_found)
    );

    // edge_armed keeps a level already present at reset release from
    // looking like an edge before in_q has captured it once.
    assign rise = bus.interrupt_in & ~in_q & {PWM_WIDTH{edge_armed}};

    always_comb begin
        clr_mask = '0;
        if (state == ACK) begin
            clr_mask[id_q] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load_id    = 1'b0;
        irq_vld_c  = 1'b0;
        int_ack_c  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.interrupt_req) begin
                    if (prio_found) begin
                        load_id    = 1'b1;
                        state_next = PRESENT;
                    end else begin
                        state_next = SPUR;
                    end
                end
            end
            PRESENT: begin
                irq_vld_c = 1'b1;
                if (bus.cpu_ack) begin
                    state_next = ACK;
                end
            end
            ACK, SPUR: begin
                int_ack_c  = 1'b1;
                state_next = HOLDOFF;
            end
            HOLDOFF: begin
                if (hold_cnt <= 8'd1) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_q       <= '0;
            edge_armed <= 1'b0;
            pending    <= '0;
            id_q       <= '0;
            hold_cnt   <= '0;
            spur_cnt   <= '0;
        end else begin
            in_q       <= bus.interrupt_in;
            edge_armed <= 1'b1;
            // OR-ing rise after the clear lets a fresh edge win over the ACK clear.
            pending    <= (pending & ~clr_mask) | rise;
            if (load_id) begin
                id_q <= prio_idx;
            end
            if (state == ACK || state == SPUR) begin
                hold_cnt <= 8'(HOLDOFF_CYCLES);
            end else if (state == HOLDOFF && hold_cnt != 8'd0) begin
                hold_cnt <= hold_cnt - 8'd1;
            end
            if (state == SPUR && spur_cnt != 8'hFF) begin
                spur_cnt <= spur_cnt + 8'd1;
            end
        end
    end

    assign bus.irq_vld      = irq_vld_c;
    assign bus.int_ack      = int_ack_c;
    assign bus.irq_id       = id_q;
    assign bus.irq_pending  = pending;
    assign bus.spurious_cnt = spur_cnt;

endmodule
